raw_data_serializer_fsm: RTL

Control FSM that pops one NUM_LANES-wide entry from the raw-data input FIFO and serialises its lanes, one per cycle, into the raw-data output FIFO. It drives the lane mux select and the push strobe. It is the parametrised successor of the fixed 4-lane push controller, with these additions:
- configurable lane count;
- write-strobe lane skipping;
- correct back-pressure, so no push is issued while the output FIFO is full;
- back-to-back entry processing with no idle bubble;
- word and drop counters.

---
 rtl/raw_data_serializer_fsm_pkg.sv | 14 +
 rtl/raw_data_serializer_fsm_lane_scan.sv | 30 +++
 rtl/raw_data_serializer_fsm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/raw_data_serializer_fsm_pkg.sv
// Shared types for the raw-data serializer: FSM state encoding and the
// strobe-handling mode constants used to configure lane skipping.
package raw_data_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PUSH = 2'd2
  } state_e;

  localparam bit SKIP_MODE_ALL    = 1'b0;
  localparam bit SKIP_MODE_STROBE = 1'b1;

endpackage

// File: rtl/raw_data_serializer_fsm_lane_scan.sv
// Combinational set-bit finder: lowest set bit of a mask, and the next set
// bit strictly above a start index (never wraps back to lane 0).
module lane_scan #(
  parameter  int NUM_LANES = 4,
  localparam int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  input  logic [IDX_W-1:0]     start_idx,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 next_valid,
  output logic [IDX_W-1:0]     low_idx
);

  // Scanning downward lets the last hit be the lowest qualifying lane.
  always_comb begin
    next_idx   = '0;
    next_valid = 1'b0;
    low_idx    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = IDX_W'(i);
        if (i > int'(start_idx)) begin
          next_idx   = IDX_W'(i);
          next_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/raw_data_serializer_fsm.sv
// Pops one multi-lane entry from the raw-data input FIFO and pushes its
// strobed lanes, one per cycle, into the raw-data output FIFO.
module raw_data_serializer_fsm
  import raw_data_pkg::*;
#(
  parameter  int NUM_LANES  = 4,
  parameter  bit SKIP_EMPTY = 1'b1,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_fifo_empty,
  input  logic [NUM_LANES-1:0] in_wstrb,
  output logic                 in_pop,
  input  logic                 out_fifo_full,
  output logic                 out_fifo_clr,
  output logic                 out_index_clr,
  output logic [IDX_W-1:0]     lane_sel,
  output logic                 push_enable,
  output logic                 encoding,
  output logic                 word_done,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     drop_count
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       lane_idx_q, lane_idx_d;
  logic [NUM_LANES-1:0]   strb_q, strb_d;
  logic [CNT_W-1:0]       word_count_q, word_count_d;
  logic [CNT_W-1:0]       drop_count_q, drop_count_d;

  logic [NUM_LANES-1:0]   eff_strb;
  logic [IDX_W-1:0]       eff_low_idx;
  logic [IDX_W-1:0]       eff_next_idx;
  logic                   eff_next_valid;
  logic [IDX_W-1:0]       strb_next_idx;
  logic                   strb_next_valid;
  logic [IDX_W-1:0]       strb_low_idx;
  logic                   unused_scan;
  logic                   take_next;

  // With skipping disabled every lane of every entry is pushed.
  assign eff_strb = (SKIP_EMPTY == SKIP_MODE_STROBE) ? in_wstrb : '1;

  lane_scan #(.NUM_LANES(NUM_LANES)) u_eff_scan (
    .mask       (eff_strb),
    .start_idx  ('0),
    .next_idx   (eff_next_idx),
    .next_valid (eff_next_valid),
    .low_idx    (eff_low_idx)
  );

  lane_scan #(.NUM_LANES(NUM_LANES)) u_strb_scan (
    .mask       (strb_q),
    .start_idx  (lane_idx_q),
    .next_idx   (strb_next_idx),
    .next_valid (strb_next_valid),
    .low_idx    (strb_low_idx)
  );

  assign unused_scan = ^{eff_next_idx, eff_next_valid, strb_low_idx};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      lane_idx_q   <= '0;
      strb_q       <= '0;
      word_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      strb_q       <= strb_d;
      word_count_q <= word_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lane_idx_d    = lane_idx_q;
    strb_d        = strb_q;
    word_count_d  = word_count_q;
    drop_count_d  = drop_count_q;
    in_pop        = 1'b0;
    out_fifo_clr  = 1'b0;
    out_index_clr = 1'b0;
    lane_sel      = '0;
    push_enable   = 1'b0;
    encoding      = 1'b0;
    word_done     = 1'b0;
    take_next     = 1'b0;

    case (state_q)
      ST_INIT: begin
        out_fifo_clr  = 1'b1;
        out_index_clr = 1'b1;
        lane_idx_d    = '0;
        strb_d        = '0;
        word_count_d  = '0;
        drop_count_d  = '0;
        state_d       = ST_IDLE;
      end
      ST_IDLE: begin
        take_next = 1'b1;
      end
      ST_PUSH: begin
        encoding = 1'b1;
        lane_sel = lane_idx_q;
        if (!out_fifo_full) begin
          push_enable = 1'b1;
          if (strb_next_valid) begin
            lane_idx_d = strb_next_idx;
          end else begin
            word_done    = 1'b1;
            word_count_d = word_count_q + 1'b1;
            take_next    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Shared load path so a finishing word can chain into the next entry.
    if (take_next) begin
      if (in_fifo_empty) begin
        state_d = ST_IDLE;
      end else begin
        in_pop = 1'b1;
        if (eff_strb == '0) begin
          drop_count_d = drop_count_q + 1'b1;
          state_d      = ST_IDLE;
        end else begin
          strb_d     = eff_strb;
          lane_idx_d = eff_low_idx;
          state_d    = ST_PUSH;
        end
      end
    end
  end

  assign word_count = word_count_q;
  assign drop_count = drop_count_q;

endmodule
